// File: rtl/commit_trace_buffer.sv
// Commit trace FIFO: captures retired MEM/WB records and presents the oldest one show-ahead.
// Optional per-record cycle stamps are enabled by defining TRACE_CYCLE_STAMP_EN.
`timescale 1ns/1ps

module commit_trace_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic                     wb_RegWrite,
  input  logic [4:0]               wb_rd,
  input  logic [31:0]              wb_Pc_Four,
  input  logic [31:0]              wb_Curr_Instr,
  input  logic [31:0]              wb_data,
  input  logic                     trace_ready,
  input  logic                     clear_ovf,
  output logic                     trace_valid,
  output logic [31:0]              trace_pc,
  output logic [31:0]              trace_instr,
  output logic [31:0]              trace_data,
  output logic [4:0]               trace_rd,
  output logic                     trace_we,
  output logic [31:0]              trace_cycle,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg,  count_next;
  logic          overflow_reg, overflow_next;
  logic [7:0]    drop_count_reg, drop_count_next;

  logic push, pop, wr_en, drop;
  logic rec_we;

  logic [31:0] mem_pc    [DEPTH];
  logic [31:0] mem_instr [DEPTH];
  logic [31:0] mem_data  [DEPTH];
  logic [4:0]  mem_rd    [DEPTH];
  logic        mem_we    [DEPTH];

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign push  = wb_valid;
  assign pop   = !empty && trace_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  // x0 writes are architecturally invisible, so they are recorded as non-writes.
  assign rec_we = wb_RegWrite && (wb_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_pc[wr_ptr_reg]    <= wb_Pc_Four - 32'd4;
      mem_instr[wr_ptr_reg] <= wb_Curr_Instr;
      mem_we[wr_ptr_reg]    <= rec_we;
      mem_rd[wr_ptr_reg]    <= rec_we ? wb_rd : 5'd0;
      mem_data[wr_ptr_reg]  <= rec_we ? wb_data : 32'd0;
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (wr_en) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    case ({wr_en, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // A drop coinciding with a clear survives as the first drop after the clear.
  always_comb begin
    overflow_next   = overflow_reg;
    drop_count_next = drop_count_reg;
    if (clear_ovf) begin
      overflow_next   = drop;
      drop_count_next = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow_next = 1'b1;
      if (drop_count_reg != 8'hFF) begin
        drop_count_next = drop_count_reg + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= 8'd0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      overflow_reg   <= overflow_next;
      drop_count_reg <= drop_count_next;
    end
  end

`ifdef TRACE_CYCLE_STAMP_EN
  logic [31:0] cycle_reg;
  logic [31:0] mem_cycle [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_reg <= 32'd0;
    end else begin
      cycle_reg <= cycle_reg + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_cycle[wr_ptr_reg] <= cycle_reg;
    end
  end

  assign trace_cycle = empty ? 32'd0 : mem_cycle[rd_ptr_reg];
`else
  assign trace_cycle = 32'd0;
`endif

  // Show-ahead head: storage is read combinationally and masked to zero when empty.
  always_comb begin
    trace_valid = !empty;
    trace_pc    = 32'd0;
    trace_instr = 32'd0;
    trace_data  = 32'd0;
    trace_rd    = 5'd0;
    trace_we    = 1'b0;
    if (!empty) begin
      trace_pc    = mem_pc[rd_ptr_reg];
      trace_instr = mem_instr[rd_ptr_reg];
      trace_data  = mem_data[rd_ptr_reg];
      trace_rd    = mem_rd[rd_ptr_reg];
      trace_we    = mem_we[rd_ptr_reg];
    end
  end

  assign count      = count_reg;
  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: queue-based reference model checked every cycle,
// plus directed literal expectations and a randomized phase.
`timescale 1ns/1ps

module tb_commit_trace_buffer;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef TRACE_CYCLE_STAMP_EN
  localparam bit STAMP = 1'b1;
`else
  localparam bit STAMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 1'b0;
  logic        wb_RegWrite = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_Pc_Four = 32'd0;
  logic [31:0] wb_Curr_Instr = 32'd0;
  logic [31:0] wb_data = 32'd0;
  logic        trace_ready = 1'b0;
  logic        clear_ovf = 1'b0;

  logic          trace_valid;
  logic [31:0]   trace_pc, trace_instr, trace_data, trace_cycle;
  logic [4:0]    trace_rd;
  logic          trace_we;
  logic [CW-1:0] count;
  logic          full, empty, overflow;
  logic [7:0]    drop_count;

  int errors = 0;
  int checks = 0;

  commit_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite),
    .wb_rd(wb_rd), .wb_Pc_Four(wb_Pc_Four), .wb_Curr_Instr(wb_Curr_Instr),
    .wb_data(wb_data), .trace_ready(trace_ready), .clear_ovf(clear_ovf),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_instr(trace_instr),
    .trace_data(trace_data), .trace_rd(trace_rd), .trace_we(trace_we),
    .trace_cycle(trace_cycle), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] stamp;
  } rec_t;

  rec_t        mq[$];
  logic        m_ovf;
  int          m_drop;
  logic [31:0] m_cyc;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advance on each edge from the sampled inputs, then compare 1 ns later.
  logic  m_push, m_pop, m_dropped;
  rec_t  m_rec, m_head;
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
      m_cyc  = 32'd0;
    end else begin
      m_push    = wb_valid;
      m_pop     = (mq.size() != 0) && trace_ready;
      m_dropped = m_push && (mq.size() == DEPTH) && !m_pop;
      if (m_pop) void'(mq.pop_front());
      if (m_push && !m_dropped) begin
        m_rec.pc    = wb_Pc_Four - 32'd4;
        m_rec.instr = wb_Curr_Instr;
        m_rec.we    = wb_RegWrite && (wb_rd != 5'd0);
        m_rec.rd    = m_rec.we ? wb_rd : 5'd0;
        m_rec.data  = m_rec.we ? wb_data : 32'd0;
        m_rec.stamp = m_cyc;
        mq.push_back(m_rec);
      end
      if (clear_ovf) begin
        m_ovf  = m_dropped;
        m_drop = m_dropped ? 1 : 0;
      end else if (m_dropped) begin
        m_ovf  = 1'b1;
        m_drop = (m_drop == 255) ? 255 : m_drop + 1;
      end
      m_cyc = m_cyc + 32'd1;
    end
    #1;
    m_head = (mq.size() != 0) ? mq[0] : '0;
    check("model_valid", 160'(trace_valid), 160'(mq.size() != 0));
    check("model_head", 160'({trace_pc, trace_instr, trace_data, trace_rd, trace_we}),
          160'({m_head.pc, m_head.instr, m_head.data, m_head.rd, m_head.we}));
    check("model_status", 160'({count, full, empty, overflow, drop_count}),
          160'({CW'(mq.size()), mq.size() == DEPTH, mq.size() == 0, m_ovf, 8'(m_drop)}));
    check("model_cycle", 160'(trace_cycle), 160'(STAMP ? m_head.stamp : 32'd0));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] pcf, input logic [31:0] instr,
                       input logic rw, input logic [4:0] rd, input logic [31:0] d,
                       input logic rdy, input logic clr);
    wb_valid      = v;
    wb_Pc_Four    = pcf;
    wb_Curr_Instr = instr;
    wb_RegWrite   = rw;
    wb_rd         = rd;
    wb_data       = d;
    trace_ready   = rdy;
    clear_ovf     = clr;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, rdy, 1'b0);
  endtask

  int pv, pr;

  initial begin
    // Reset state
    step();
    step();
    check("rst_trace_valid", 160'(trace_valid), 160'(0));
    check("rst_empty_full", 160'({empty, full}), 160'(2'b10));
    check("rst_count", 160'(count), 160'(0));
    check("rst_pc", 160'(trace_pc), 160'(0));
    reset = 1'b0;

    // Cycles 0..2 idle, first push at cycle 3
    idle(1'b0);
    repeat (3) step();
    drive(1'b1, 32'h10, 32'h00A00093, 1'b1, 5'd1, 32'd10, 1'b0, 1'b0);
    step();
    check("first_valid", 160'(trace_valid), 160'(1));
    check("first_pc", 160'(trace_pc), 160'(32'h0C));
    check("first_fields", 160'({trace_we, trace_rd, trace_data}), 160'({1'b1, 5'd1, 32'd10}));
    check("first_count", 160'(count), 160'(1));
    check("first_cycle", 160'(trace_cycle), 160'(STAMP ? 32'd3 : 32'd0));

    // Cycles 4..6 idle, cycle 7 push to x0 while popping the first record
    idle(1'b0);
    repeat (3) step();
    drive(1'b1, 32'h14, 32'h00500013, 1'b1, 5'd0, 32'd5, 1'b1, 1'b0);
    step();
    check("x0_fields", 160'({trace_we, trace_rd, trace_data}), 160'(0));
    check("x0_pc", 160'(trace_pc), 160'(32'h10));
    check("x0_count", 160'(count), 160'(1));
    check("x0_cycle", 160'(trace_cycle), 160'(STAMP ? 32'd7 : 32'd0));
    idle(1'b1);
    step();
    check("drain_empty", 160'({empty, trace_valid, trace_pc}), 160'({1'b1, 1'b0, 32'd0}));

    // Ten pushes into a depth-8 FIFO
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 32'h13 + 32'(i), 1'b1, 5'(i + 1), 32'(i + 1), 1'b0, 1'b0);
      step();
    end
    idle(1'b0);
    check("fill_status", 160'({full, count, overflow, drop_count}),
          160'({1'b1, CW'(8), 1'b1, 8'd2}));
    for (int i = 0; i < 8; i++) begin
      check("order_pc", 160'(trace_pc), 160'(32'hFC + 32'(4 * i)));
      check("order_data", 160'(trace_data), 160'(32'(i + 1)));
      idle(1'b1);
      step();
    end
    check("order_empty", 160'({empty, count}), 160'({1'b1, CW'(0)}));

    // Refill, then simultaneous push/pop while full
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 32'h33, 1'b1, 5'd3, 32'(100 + i), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h300, 32'h33, 1'b1, 5'd4, 32'd999, 1'b1, 1'b0);
    step();
    check("fullpp_status", 160'({count, overflow, drop_count}), 160'({CW'(8), 1'b1, 8'd2}));
    check("fullpp_head", 160'(trace_pc), 160'(32'h200));
    drive(1'b1, 32'h400, 32'h33, 1'b1, 5'd4, 32'd1, 1'b0, 1'b1);
    step();
    check("clr_drop", 160'({overflow, drop_count}), 160'({1'b1, 8'd1}));
    drive(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    step();
    check("clr_only", 160'({overflow, drop_count}), 160'({1'b0, 8'd0}));

    // Drop counter saturation
    drive(1'b1, 32'h500, 32'h33, 1'b1, 5'd5, 32'd5, 1'b0, 1'b0);
    repeat (300) step();
    check("sat_drop", 160'({overflow, drop_count}), 160'({1'b1, 8'd255}));

    // Asynchronous reset mid-stream with five entries
    idle(1'b1);
    repeat (3) step();
    check("pre_rst_count", 160'(count), 160'(5));
    idle(1'b0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst", 160'({trace_valid, count, empty}), 160'({1'b0, CW'(0), 1'b1}));
    check("async_rst_ovf", 160'({overflow, drop_count}), 160'(0));
    step();
    reset = 1'b0;

    // PC wraps below zero
    drive(1'b1, 32'd0, 32'h13, 1'b0, 5'd7, 32'd7, 1'b0, 1'b0);
    step();
    check("pc_wrap", 160'({trace_pc, trace_we, trace_rd}), 160'({32'hFFFF_FFFC, 1'b0, 5'd0}));
    idle(1'b1);
    step();

    // Randomized traffic with varying push/pop pressure
    pv = 50;
    pr = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        pv = $urandom_range(10, 100);
        pr = $urandom_range(10, 100);
      end
      reset = ($urandom_range(0, 999) == 0);
      drive($urandom_range(0, 99) < pv,
            ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 7)) : $urandom,
            $urandom, 1'($urandom),
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
            $urandom, $urandom_range(0, 99) < pr, $urandom_range(0, 49) == 0);
      step();
    end
    reset = 1'b0;
    idle(1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
